// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state encoding, default widths and helpers for mem_bus_master
package mem_bus_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int STATS_WIDTH           = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } bus_state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_bus_stats.sv
// rtl/mem_bus_stats.sv - saturating completed-read/write counters for mem_bus_master
module mem_bus_stats
    import mem_bus_pkg::*;
(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   rd_done,
    input  logic                   wr_done,
    output logic [STATS_WIDTH-1:0] rd_count,
    output logic [STATS_WIDTH-1:0] wr_count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_done) begin
                rd_count <= sat_inc(rd_count);
            end
            if (wr_done) begin
                wr_count <= sat_inc(wr_count);
            end
        end
    end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - request/response master for a shared tri-state memory bus
// Optional MEM_BUS_STATS_EN adds saturating rd_count/wr_count outputs.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_we,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rd,
    output logic                     wr,
    output logic                     data_e,
    output logic [ADDRESS_WIDTH-1:0] mux_add_in,
    inout  wire  [DATA_WIDTH-1:0]    data
`ifdef MEM_BUS_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]   rd_count,
    output logic [STATS_WIDTH-1:0]   wr_count
`endif
);

    bus_state_t            state;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign req_ready = (state == IDLE);

    // data_e is only high in WRITE, so the bus is released in every other state
    // and immediately on reset assertion.
    assign data = data_e ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            data_e     <= 1'b0;
            mux_add_in <= '0;
            rsp_valid  <= 1'b0;
            rsp_we     <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        wdata_q    <= req_wdata;
                        mux_add_in <= req_addr;
                        if (req_we) begin
                            state  <= WRITE;
                            wr     <= 1'b1;
                            data_e <= 1'b1;
                        end else begin
                            state <= RD_ADDR;
                            rd    <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state      <= IDLE;
                    wr         <= 1'b0;
                    data_e     <= 1'b0;
                    mux_add_in <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_we     <= we_q;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    // Memory output register is valid on the bus during this cycle.
                    rsp_rdata  <= data;
                    state      <= IDLE;
                    rd         <= 1'b0;
                    mux_add_in <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_we     <= we_q;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_BUS_STATS_EN
    mem_bus_stats u_stats (
        .clk      (clk),
        .n_rst    (n_rst),
        .rd_done  (state == RD_DATA),
        .wr_done  (state == WRITE),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );
`endif

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the shared data bus and request data.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, width of the memory address.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  requester has a transaction pending.
REQ-006 SHALL have port req_ready  output  1  block accepts a transaction this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDRESS_WIDTH  transaction address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_we  output  1  type of the completed transaction.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data; held until the next read completes.
REQ-013 SHALL have port rd  output  1  memory read strobe.
REQ-014 SHALL have port wr  output  1  memory write strobe.
REQ-015 SHALL have port data_e  output  1  write data enable.
REQ-016 SHALL have port mux_add_in  output  ADDRESS_WIDTH  memory address.
REQ-017 SHALL have port data  inout  DATA_WIDTH  shared tri-state data bus.

Function
REQ-018 SHALL implement the states IDLE, WRITE, RD_ADDR and RD_DATA.
REQ-019 SHALL assert req_ready only in IDLE; a transfer occurs on req_valid && req_ready at a rising edge.
REQ-020 SHALL latch req_we, req_addr and req_wdata on acceptance and ignore request inputs while not in IDLE.
REQ-021 SHALL sequence an accepted write as IDLE->WRITE->IDLE, with WRITE lasting exactly one cycle.
REQ-022 SHALL, in WRITE, drive wr=1, data_e=1, rd=0, mux_add_in=latched address and data=latched write data.
REQ-023 SHALL sequence an accepted read as IDLE->RD_ADDR->RD_DATA->IDLE, one cycle each.
REQ-024 SHALL hold rd=1, wr=0, data_e=0 and the latched address in RD_ADDR and RD_DATA.
REQ-025 SHALL capture the data bus into rsp_rdata at the end of RD_DATA, the cycle in which the memory drives its registered output.
REQ-026 SHALL drive data only in WRITE and leave it at all-Z in every other state; rd and wr are never both 1.
REQ-027 SHALL pulse rsp_valid for the first IDLE cycle after WRITE or RD_DATA, with rsp_we = type of the completed transaction.
REQ-028 SHALL be able to accept a new request in that same cycle (back-to-back): write throughput is one per 2 cycles, read one per 3.
REQ-029 SHALL drive rd, wr and data_e to 0 and mux_add_in to 0 in IDLE.

Reset
REQ-030 SHALL, on n_rst low at any time including mid-transaction, immediately enter IDLE, release data to Z, abandon the transaction without rsp_valid, and clear rd, wr, data_e, mux_add_in, rsp_valid, rsp_we and rsp_rdata to 0.
REQ-031 SHALL reach req_ready=1 on reset release; the first acceptance occurs at the first rising edge with n_rst high.

Configuration
REQ-032 SHALL, with MEM_BUS_STATS_EN defined, add outputs rd_count and wr_count, each 16 bits, counting completed reads and writes, saturating at 16'hFFFF and reset to 0.
REQ-033 SHALL, without MEM_BUS_STATS_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-034 SHALL take its state encoding and default width constants from shared package mem_bus_pkg.
REQ-035 SHALL place the saturating counters in sub-module mem_bus_stats, instantiated only under MEM_BUS_STATS_EN.

Verification
REQ-036 SHALL cover write then read: write addr 5'h03 data 8'hA5, then read 5'h03 -> rsp_valid 2 and then 3 cycles after acceptance, rsp_rdata=8'hA5.
REQ-037 SHALL cover back-to-back requests: req_valid held with four alternating writes and reads to 5'h1F -> accepted every 2 or 3 cycles, no idle gap, and data=Z whenever rd=1.
REQ-038 SHALL cover busy cycles: req_addr changed to 5'h07 during RD_ADDR -> the transaction completes using the original address.
REQ-039 SHALL cover mid-transaction reset: n_rst low during RD_DATA -> next cycle rd=0, data=Z, rsp_valid never asserted, rsp_rdata=0.
REQ-040 SHALL cover bus release: a reset-default memory read of 5'h00 -> rsp_rdata equals the preloaded word, and the master never drives data during the read.
REQ-041 SHALL cover the stats feature under MEM_BUS_STATS_EN: 70000 writes -> wr_count=16'hFFFF and rd_count unchanged.
